// File: rtl/mult_axil_pkg.sv
// Shared register offsets, CTRL bit positions, response codes and FSM states
// for the AXI4-Lite multiplier endpoint.
package mult_axil_pkg;

    localparam logic [3:0] ADDR_OPA    = 4'h0;
    localparam logic [3:0] ADDR_OPB    = 4'h4;
    localparam logic [3:0] ADDR_CTRL   = 4'h8;
    localparam logic [3:0] ADDR_RESULT = 4'hC;

    // CTRL write bits: start / irq_en / done-clear; read bits: busy / irq_en / done
    localparam int CTRL_START  = 0;
    localparam int CTRL_BUSY   = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int CTRL_DONE   = 2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mult_state_e;

endpackage

// File: rtl/seq_mult.sv
// Sequential shift-add multiplier: operands latched on start, one partial
// product per cycle for OP_WIDTH cycles, done pulses on the final step.
module seq_mult
    import mult_axil_pkg::*;
#(
    parameter int OP_WIDTH = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [OP_WIDTH-1:0]   a_i,
    input  logic [OP_WIDTH-1:0]   b_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [2*OP_WIDTH-1:0] product_o
);

    localparam int CW = (OP_WIDTH > 1) ? $clog2(OP_WIDTH) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(OP_WIDTH - 1);

    mult_state_e           state_q, state_d;
    logic [2*OP_WIDTH-1:0] mcand_q, mcand_d;
    logic [OP_WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*OP_WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [2*OP_WIDTH-1:0] step_sum;

    assign step_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);
    // Only meaningful while done_o is high: the accumulator after the last step.
    assign product_o = step_sum;
    assign busy_o    = (state_q == ST_RUN);

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        done_o   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d  = ST_RUN;
                    mcand_d  = {{OP_WIDTH{1'b0}}, a_i};
                    mplier_d = b_i;
                    acc_d    = '0;
                    cnt_d    = '0;
                end
            end
            ST_RUN: begin
                acc_d    = step_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST_STEP) begin
                    state_d = ST_IDLE;
                    done_o  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/mult_axil_slave.sv
// AXI4-Lite slave exposing OPA/OPB/CTRL/RESULT around the shift-add multiplier;
// one outstanding write and one outstanding read at a time.
module mult_axil_slave
    import mult_axil_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int OP_WIDTH           = 16
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic                            irq
);

    localparam int NB = (OP_WIDTH + 7) / 8;

    logic                          awready_q, awready_d;
    logic                          bvalid_q, bvalid_d;
    logic [1:0]                    bresp_q, bresp_d;
    logic                          arready_q, arready_d;
    logic                          rvalid_q, rvalid_d;
    logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [OP_WIDTH-1:0]           opa_q, opa_d;
    logic [OP_WIDTH-1:0]           opb_q, opb_d;
    logic                          irq_en_q, irq_en_d;
    logic                          done_q, done_d;
    logic [2*OP_WIDTH-1:0]         result_q, result_d;

    logic                          wr_en, rd_en, ctrl_wr, mult_start, start_accept;
    logic [1:0]                    wr_sel, rd_sel;
    logic [OP_WIDTH-1:0]           opa_wr_val, opb_wr_val;
    logic [C_S_AXI_DATA_WIDTH-1:0] rd_mux;
    logic                          mult_busy, mult_done;
    logic [2*OP_WIDTH-1:0]         mult_product;
    logic                          unused_bits;

    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR,
                           S_AXI_WDATA, S_AXI_WSTRB};

    // The ready pulse is only raised while both valids are up, so a held
    // valid guarantees the handshake completes in the pulse cycle.
    assign wr_en        = awready_q & S_AXI_AWVALID & S_AXI_WVALID;
    assign rd_en        = arready_q & S_AXI_ARVALID;
    assign wr_sel       = S_AXI_AWADDR[3:2];
    assign rd_sel       = S_AXI_ARADDR[3:2];
    assign ctrl_wr      = wr_en & (wr_sel == ADDR_CTRL[3:2]) & S_AXI_WSTRB[0];
    assign mult_start   = ctrl_wr & S_AXI_WDATA[CTRL_START];
    assign start_accept = mult_start & ~mult_busy;

    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_lane
            localparam int LO = gi * 8;
            localparam int HI = (gi * 8 + 7 < OP_WIDTH) ? gi * 8 + 7 : OP_WIDTH - 1;
            assign opa_wr_val[HI:LO] = S_AXI_WSTRB[gi] ? S_AXI_WDATA[HI:LO] : opa_q[HI:LO];
            assign opb_wr_val[HI:LO] = S_AXI_WSTRB[gi] ? S_AXI_WDATA[HI:LO] : opb_q[HI:LO];
        end
    endgenerate

    always_comb begin
        rd_mux = '0;
        case (rd_sel)
            ADDR_OPA[3:2]:    rd_mux = C_S_AXI_DATA_WIDTH'(opa_q);
            ADDR_OPB[3:2]:    rd_mux = C_S_AXI_DATA_WIDTH'(opb_q);
            ADDR_CTRL[3:2]:   rd_mux = C_S_AXI_DATA_WIDTH'({done_q, irq_en_q, mult_busy});
            ADDR_RESULT[3:2]: rd_mux = C_S_AXI_DATA_WIDTH'(result_q);
            default:          rd_mux = '0;
        endcase
    end

    always_comb begin
        awready_d = ~awready_q & S_AXI_AWVALID & S_AXI_WVALID & ~bvalid_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        arready_d = ~arready_q & S_AXI_ARVALID & ~rvalid_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        irq_en_d  = irq_en_q;
        done_d    = done_q;
        result_d  = result_q;

        if (bvalid_q && S_AXI_BREADY) bvalid_d = 1'b0;
        if (wr_en) begin
            bvalid_d = 1'b1;
            bresp_d  = (wr_sel == ADDR_RESULT[3:2]) ? RESP_SLVERR : RESP_OKAY;
            if (wr_sel == ADDR_OPA[3:2]) opa_d = opa_wr_val;
            if (wr_sel == ADDR_OPB[3:2]) opb_d = opb_wr_val;
        end

        if (ctrl_wr) irq_en_d = S_AXI_WDATA[CTRL_IRQ_EN];
        // Completion is applied last so it beats a same-cycle done-clear.
        if (ctrl_wr && S_AXI_WDATA[CTRL_DONE]) done_d = 1'b0;
        if (start_accept) done_d = 1'b0;
        if (mult_done) begin
            done_d   = 1'b1;
            result_d = mult_product;
        end

        if (rvalid_q && S_AXI_RREADY) rvalid_d = 1'b0;
        if (rd_en) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_mux;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            awready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            irq_en_q  <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
        end else begin
            awready_q <= awready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            irq_en_q  <= irq_en_d;
            done_q    <= done_d;
            result_q  <= result_d;
        end
    end

    seq_mult #(
        .OP_WIDTH (OP_WIDTH)
    ) u_seq_mult (
        .clk_i     (ACLK),
        .rst_ni    (ARESETN),
        .start_i   (mult_start),
        .a_i       (opa_q),
        .b_i       (opb_q),
        .busy_o    (mult_busy),
        .done_o    (mult_done),
        .product_o (mult_product)
    );

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = awready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = RESP_OKAY;
    assign irq           = done_q & irq_en_q;

endmodule
